// File: rtl/rgb_fade_sequencer.sv
// Sequencer for a three-channel LED PWM block. It steps the duty values toward a target
// or around the hue wheel at a programmable tick rate.
module rgb_fade_sequencer #(
    parameter int unsigned PRESCALE_W       = 16,
    parameter int unsigned DEFAULT_PRESCALE = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [23:0]           cfg_color,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic [7:0]            duty0,
    output logic [7:0]            duty1,
    output logic [7:0]            duty2,
    output logic                  duty_load,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StFade, StCycle, StHold} state_e;
    typedef enum logic [1:0] {Phase0, Phase1, Phase2} phase_e;

    localparam logic [1:0] ModeOff   = 2'd0;
    localparam logic [1:0] ModeSolid = 2'd1;
    localparam logic [1:0] ModeCycle = 2'd2;
    localparam logic [1:0] ModeHold  = 2'd3;

    localparam logic [PRESCALE_W-1:0] PsZero = '0;
    localparam logic [PRESCALE_W-1:0] PsOne  = PsZero + 1'b1;
    localparam logic [PRESCALE_W-1:0] PsRst  = PRESCALE_W'(DEFAULT_PRESCALE);

    // Index 0 is red, 1 green, 2 blue.
    localparam logic [2:0][7:0] Red = {8'd0, 8'd0, 8'd255};

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [2:0][7:0]       tgt_q, tgt_d;
    logic [2:0][7:0]       duty_q, duty_d;
    logic                  load_q, load_d;
    logic                  busy_q;

    logic            accept;
    logic            running;
    logic            tick;
    logic [2:0][7:0] cmd_tgt;
    logic [2:0][7:0] fade_step;

    assign cfg_ready = (state_q != StFade);
    assign accept    = cfg_valid && cfg_ready;
    assign running   = (state_q == StFade) || (state_q == StCycle);
    assign tick      = running && (cnt_q == prescale_q - PsOne);

    always_comb begin
        cmd_tgt = '0;
        if (cfg_mode == ModeSolid) begin
            cmd_tgt[0] = cfg_color[23:16];
            cmd_tgt[1] = cfg_color[15:8];
            cmd_tgt[2] = cfg_color[7:0];
        end
    end

    always_comb begin
        fade_step = duty_q;
        for (int i = 0; i < 3; i++) begin
            if (duty_q[i] < tgt_q[i]) begin
                fade_step[i] = duty_q[i] + 8'd1;
            end else if (duty_q[i] > tgt_q[i]) begin
                fade_step[i] = duty_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        prescale_d = prescale_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        tgt_d      = tgt_q;
        duty_d     = duty_q;
        load_d     = 1'b0;

        if (running) begin
            cnt_d = tick ? PsZero : cnt_q + PsOne;
        end

        if (accept) begin
            // A new command preempts any cycle step due on this edge.
            prescale_d = (cfg_prescale == PsZero) ? PsOne : cfg_prescale;
            cnt_d      = PsZero;
            unique case (cfg_mode)
                ModeOff, ModeSolid: begin
                    tgt_d     = cmd_tgt;
                    pending_d = 1'b0;
                    state_d   = (duty_q == cmd_tgt) ? StIdle : StFade;
                end
                ModeCycle: begin
                    if (duty_q == Red) begin
                        state_d   = StCycle;
                        phase_d   = Phase0;
                        pending_d = 1'b0;
                    end else begin
                        tgt_d     = Red;
                        pending_d = 1'b1;
                        state_d   = StFade;
                    end
                end
                ModeHold: begin
                    state_d = StHold;
                end
                default: state_d = state_q;
            endcase
        end else if (tick) begin
            load_d = 1'b1;
            if (state_q == StFade) begin
                duty_d = fade_step;
                if (fade_step == tgt_q) begin
                    state_d   = pending_q ? StCycle : StIdle;
                    phase_d   = Phase0;
                    pending_d = 1'b0;
                end
            end else begin
                // Hue wheel: one channel drains into the next, sum stays at 255.
                unique case (phase_q)
                    Phase0: begin
                        duty_d[0] = duty_q[0] - 8'd1;
                        duty_d[1] = duty_q[1] + 8'd1;
                        if (duty_q[0] == 8'd1) phase_d = Phase1;
                    end
                    Phase1: begin
                        duty_d[1] = duty_q[1] - 8'd1;
                        duty_d[2] = duty_q[2] + 8'd1;
                        if (duty_q[1] == 8'd1) phase_d = Phase2;
                    end
                    Phase2: begin
                        duty_d[2] = duty_q[2] - 8'd1;
                        duty_d[0] = duty_q[0] + 8'd1;
                        if (duty_q[2] == 8'd1) phase_d = Phase0;
                    end
                    default: phase_d = Phase0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            phase_q    <= Phase0;
            prescale_q <= PsRst;
            cnt_q      <= PsZero;
            pending_q  <= 1'b0;
            tgt_q      <= '0;
            duty_q     <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            tgt_q      <= tgt_d;
            duty_q     <= duty_d;
            load_q     <= load_d;
            busy_q     <= (state_d == StFade) || (state_d == StCycle);
        end
    end

    assign duty0     = duty_q[0];
    assign duty1     = duty_q[1];
    assign duty2     = duty_q[2];
    assign duty_load = load_q;
    assign busy      = busy_q;

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Controller that sequences the 3-channel LED PWM datapath. It accepts colour/mode commands over a valid/ready handshake and steps the three 8-bit duty values toward a target at a programmable tick rate. Modes are fade-to-colour, fade-to-off, continuous hue-wheel cycle, and hold. It sits between the SoC/top-level control logic and the PWM block, driving the PWM duty inputs and load strobe.

Parameters:
PRESCALE_W, 16, width of the step-rate prescaler and of cfg_prescale
DEFAULT_PRESCALE, 128, prescale value loaded at reset

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
cfg_valid  input  1  command valid
cfg_ready  output  1  command accepted when cfg_valid && cfg_ready
cfg_mode  input  2  0=OFF, 1=SOLID, 2=CYCLE, 3=HOLD
cfg_color  input  24  SOLID target {R[23:16], G[15:8], B[7:0]}
cfg_prescale  input  PRESCALE_W  clk cycles per step; 0 is treated as 1
duty0  output  8  red duty
duty1  output  8  green duty
duty2  output  8  blue duty
duty_load  output  1  one-cycle strobe: duty0..2 hold new values, PWM latches them
busy  output  1  high in FADE or CYCLE

Behaviour:
- Reset (async, resetn low): state=IDLE, duty0..2=0, duty_load=0, busy=0, cfg_ready=1, prescale reg=DEFAULT_PRESCALE, prescaler count=0, cycle_pending=0, phase=P0.
- States: IDLE, FADE, CYCLE, HOLD. cfg_ready = (state != FADE). cfg_valid while cfg_ready=0 is ignored; no queuing.
- On accept: latch prescale (0 becomes 1) and clear the prescaler count. The new state takes effect on the accept edge. Handling by mode:
  - OFF: target=(0,0,0).
  - SOLID: target=cfg_color.
  - OFF/SOLID with duties already equal to target: go to IDLE, no duty_load. Otherwise go to FADE, cycle_pending=0.
  - CYCLE: if duties==(255,0,0), go to CYCLE with phase P0. Otherwise target=(255,0,0), cycle_pending=1, go to FADE.
  - HOLD: go to HOLD. The prescaler stops, duties freeze, no duty_load.
- Prescaler: runs only in FADE and CYCLE. It counts 0..prescale-1. tick = (count == prescale-1), and count wraps to 0 on tick. The first tick occurs exactly prescale cycles after the accept edge.
- FADE, on tick:
  - Each channel steps ±1 toward its target independently; a channel already at target is unchanged.
  - duty_load=1 on the same edge the duties update.
  - When all channels reach target on that tick: go to CYCLE (P0) if cycle_pending, else IDLE. Clear cycle_pending.
- CYCLE, on tick (duty_load=1 every tick):
  - P0: duty0--, duty1++. Phase goes to P1 on the tick where duty0 becomes 0.
  - P1: duty1--, duty2++. Goes to P2 when duty1 becomes 0.
  - P2: duty2--, duty0++. Goes to P0 when duty2 becomes 0.
  - Sum is invariant at 255 with no wrap. A full wheel is 765 ticks.
- CYCLE stays until a new command is accepted. An accept during CYCLE preempts on that edge, with no duty_load that cycle.
- Arithmetic: duties never wrap. Steps are saturating by construction, since targets are 0..255.
- busy = (state==FADE || state==CYCLE), registered with state.
- If resetn is asserted mid-operation, all outputs go to reset values immediately, independent of clk.

Test Plan:
1. Assert resetn low mid-FADE, async, between clk edges -> duty0..2=0, duty_load=0, busy=0, cfg_ready=1 immediately.
2. Send SOLID 0x030100 with prescale=1 from reset -> duty_load on 3 consecutive cycles: (1,1,0), (2,1,0), (3,1,0). Then IDLE, busy=0, cfg_ready=1.
3. Send SOLID 0x000002 with prescale=4 -> first duty_load exactly 4 cycles after accept, second 8 cycles after accept, then IDLE. Repeat with prescale=0 -> loads on consecutive cycles (prescale treated as 1).
4. Send CYCLE from (0,0,0) with prescale=1 -> 255 loads reach (255,0,0). After 255 more: (0,255,0). After 510 more: (255,0,0). r+g+b=255 throughout the wheel; busy=1 throughout.
5. Pulse cfg_valid during FADE -> cfg_ready=0, command ignored, fade completes unchanged. Send HOLD during CYCLE -> duties frozen, no duty_load for 1000 cycles, busy=0.
6. Send SOLID equal to the current duties -> accepted, stays IDLE, no duty_load. Send OFF from (10,200,0) -> 200 loads ending at (0,0,0).
